fp_norm_round: RTL and testbench

FP_NORM_ROUND -- requirements
Module: fp_norm_round

---
 rtl/fp_norm_round.sv | 176 +++++++++++++++++
 tb/tb_fp_norm_round.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fp_norm_round.sv
// Post-add normaliser and rounder for IEEE-754 single precision.
// Takes an unnormalised 28-bit mantissa with GRS bits and packs the final result.
module fp_norm_round #(
    parameter int ROUND_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [27:0] in_mantis,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] MAX_LSHIFT = 5'd26;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [27:0] mant_q, mant_d;
    logic [9:0]  exp_q, exp_d;
    logic [4:0]  shift_q, shift_d;
    logic        inf_q, inf_d;
    logic        nz_q, nz_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic        rnd_inc;
    logic [24:0] rnd_sum;
    logic        rnd_hidden;
    logic [22:0] rnd_frac;
    logic [9:0]  rnd_exp;
    logic [7:0]  pack_field;
    logic [31:0] pack_result;
    logic        pack_ovf;
    logic        pack_unf;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            mant_q   <= 28'd0;
            exp_q    <= 10'd0;
            shift_q  <= 5'd0;
            inf_q    <= 1'b0;
            nz_q     <= 1'b0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            shift_q  <= shift_d;
            inf_q    <= inf_d;
            nz_q     <= nz_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Rounding of mant_q[26:3]; guard/round/sticky are bits 2/1/0, LSB is bit 3
    always_comb begin
        rnd_inc = (ROUND_MODE == 0) && mant_q[2] && (mant_q[1] | mant_q[0] | mant_q[3]);
        rnd_sum = {1'b0, mant_q[26:3]} + {24'd0, rnd_inc};
        if (rnd_sum[24]) begin
            rnd_hidden = 1'b1;
            rnd_frac   = 23'd0;
            rnd_exp    = exp_q + 10'd1;
        end else begin
            rnd_hidden = rnd_sum[23];
            rnd_frac   = rnd_sum[22:0];
            rnd_exp    = exp_q;
        end
    end

    // Final packing; an infinite operand overrides whatever normalisation did
    always_comb begin
        pack_field  = rnd_hidden ? rnd_exp[7:0] : 8'd0;
        pack_result = {sign_q, pack_field, rnd_frac};
        pack_ovf    = 1'b0;
        pack_unf    = nz_q && (pack_field == 8'd0);
        if (inf_q || (rnd_exp >= 10'd255)) begin
            pack_result = {sign_q, 8'hFF, 23'd0};
            pack_ovf    = 1'b1;
            pack_unf    = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        shift_d  = shift_q;
        inf_d    = inf_q;
        nz_d     = nz_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    mant_d  = in_mantis;
                    exp_d   = (in_exp == 8'd0) ? 10'd1 : {2'b00, in_exp};
                    shift_d = 5'd0;
                    inf_d   = (in_exp == 8'hFF);
                    nz_d    = (in_mantis != 28'd0);
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mant_q == 28'd0) begin
                    result_d = inf_q ? {sign_q, 8'hFF, 23'd0} : {sign_q, 31'd0};
                    ovf_d    = inf_q;
                    unf_d    = 1'b0;
                    state_d  = DONE;
                end else if (mant_q[27]) begin
                    mant_d = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + 10'd1;
                end else if (mant_q[26]) begin
                    state_d = ROUND;
                end else if (exp_q <= 10'd1) begin
                    state_d = ROUND;
                end else if (shift_q == MAX_LSHIFT) begin
                    state_d = ROUND;
                end else begin
                    mant_d  = {mant_q[26:0], 1'b0};
                    exp_d   = exp_q - 10'd1;
                    shift_d = shift_q + 5'd1;
                end
            end
            ROUND: begin
                result_d = pack_result;
                ovf_d    = pack_ovf;
                unf_d    = pack_unf;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign out_result    = result_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: both rounding modes driven in parallel
// with hand-computed results, latencies and handshake behaviour.
module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'd0;
    logic [27:0] in_mantis = 28'd0;
    logic        out_ready = 1'b1;

    logic        in_ready0, out_valid0, ovf0, unf0;
    logic        in_ready1, out_valid1, ovf1, unf1;
    logic [31:0] res0, res1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fp_norm_round #(.ROUND_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_sign(in_sign), .in_exp(in_exp), .in_mantis(in_mantis),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_result(res0), .out_overflow(ovf0), .out_underflow(unf0)
    );

    fp_norm_round #(.ROUND_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_sign(in_sign), .in_exp(in_exp), .in_mantis(in_mantis),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_result(res1), .out_overflow(ovf1), .out_underflow(unf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Present one operand, time out_valid from the accepting edge, check the packed result
    task automatic run_op(input string tag, input logic s, input logic [7:0] e, input logic [27:0] m,
                          input int lat, input logic [31:0] r0, input logic [31:0] r1,
                          input logic ovf, input logic unf);
        int n;
        check({tag, "_in_ready"}, {31'd0, in_ready0 & in_ready1}, 32'd1);
        @(negedge clk);
        in_sign = s; in_exp = e; in_mantis = m; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (n < 60 && !out_valid0) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_valid1"}, {31'd0, out_valid1}, 32'd1);
        check({tag, "_res0"}, res0, r0);
        check({tag, "_res1"}, res1, r1);
        check({tag, "_ovf"}, {30'd0, ovf0, ovf1}, {30'd0, ovf, ovf});
        check({tag, "_unf"}, {30'd0, unf0, unf1}, {30'd0, unf, unf});
        $display("op %s sign=%0d exp=%h mantis=%h -> %h/%h after %0d edges", tag, s, e, m, res0, res1, n);
        if (out_ready) begin
            @(posedge clk);
            #1 check({tag, "_back_idle"}, {30'd0, in_ready0, out_valid0}, 32'd2);
        end
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready0}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        check("rst_result", res0, 32'd0);
        check("rst_flags", {30'd0, ovf0, unf0}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("one",     1'b0, 8'h7F, 28'h4000000, 2,  32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
        run_op("carry",   1'b0, 8'h7F, 28'h8000000, 3,  32'h40000000, 32'h40000000, 1'b0, 1'b0);
        run_op("lshift",  1'b0, 8'h7F, 28'h0000008, 25, 32'h34000000, 32'h34000000, 1'b0, 1'b0);
        run_op("tie",     1'b0, 8'h7F, 28'h7FFFFFC, 2,  32'h40000000, 32'h3FFFFFFF, 1'b0, 1'b0);
        run_op("zero",    1'b1, 8'h7F, 28'h0000000, 1,  32'h80000000, 32'h80000000, 1'b0, 1'b0);
        run_op("ovf",     1'b0, 8'hFE, 28'h8000000, 3,  32'h7F800000, 32'h7F800000, 1'b1, 1'b0);
        run_op("inf_in",  1'b1, 8'hFF, 28'h4000000, 2,  32'hFF800000, 32'hFF800000, 1'b1, 1'b0);
        run_op("denorm",  1'b0, 8'h00, 28'h2000000, 2,  32'h00400000, 32'h00400000, 1'b0, 1'b1);

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        run_op("hold", 1'b0, 8'h7F, 28'h4000000, 2, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, out_valid0}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready0}, 32'd0);
            check("hold_result", res0, 32'h3F800000);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 check("hold_release", {30'd0, in_ready0, out_valid0}, 32'd2);

        // Reset in the middle of normalisation drops the operand
        @(negedge clk);
        in_sign = 1'b0; in_exp = 8'h7F; in_mantis = 28'h0000008; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready", {31'd0, in_ready0}, 32'd1);
        check("midrst_valid", {31'd0, out_valid0}, 32'd0);
        check("midrst_result", res0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1 if (out_valid0 || out_valid1) seen++;
        end
        check("midrst_never_valid", seen, 0);
        $display("op midrst dropped, valid cycles seen=%0d", seen);

        run_op("after_rst", 1'b0, 8'h7F, 28'h4000000, 2, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
